// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control registers and hazard logic.
package pipe_ctrl_pkg;

  // R15 reads return the PC, so they never take a forwarded value.
  localparam logic [3:0] REG_PC = 4'hF;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  // Everything the D->E register carries; a bubble is simply '0.
  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       pc_src;
    logic       alu_src;
    logic [1:0] alu_control;
    logic [1:0] flag_write;
    logic [3:0] cond;
    logic [3:0] wa3;
    logic [3:0] ra1;
    logic [3:0] ra2;
  } ctrl_e_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_to_reg;
    logic       pc_src;
    logic [3:0] wa3;
  } ctrl_m_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       pc_src;
    logic [3:0] wa3;
  } ctrl_w_t;

  // Forwarding select for one E-stage source register; the younger M result wins over W.
  function automatic fwd_sel_t fwd_select(input logic [3:0] ra_e,
                                          input logic       reg_write_m,
                                          input logic [3:0] wa3_m,
                                          input logic       reg_write_w,
                                          input logic [3:0] wa3_w);
    fwd_sel_t sel;
    sel = FWD_RF;
    if (ra_e != REG_PC) begin
      if (reg_write_m && (wa3_m == ra_e)) begin
        sel = FWD_MEM;
      end else if (reg_write_w && (wa3_w == ra_e)) begin
        sel = FWD_WB;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_unit.sv
// Combinational forwarding, stall and flush generation for the 5-stage pipeline.
module hazard_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [3:0] ra1_d,
  input  logic [3:0] ra2_d,
  input  logic [3:0] ra1_e,
  input  logic [3:0] ra2_e,
  input  logic [3:0] wa3_e,
  input  logic       mem_to_reg_e,
  input  logic       reg_write_m,
  input  logic [3:0] wa3_m,
  input  logic       reg_write_w,
  input  logic [3:0] wa3_w,
  input  logic       pc_src_d,
  input  logic       pc_src_e,
  input  logic       pc_src_m,
  input  logic       pc_src_w,
  input  logic       branch_taken_e,
  output fwd_sel_t   forward_a_e,
  output fwd_sel_t   forward_b_e,
  output logic       stall_f,
  output logic       stall_d,
  output logic       flush_d,
  output logic       flush_e
);

  logic ldr_stall;
  logic pc_wr_pend;

  // Forwarding selects, load-use detection and pending PC writes.
  always_comb begin
    forward_a_e = fwd_select(ra1_e, reg_write_m, wa3_m, reg_write_w, wa3_w);
    forward_b_e = fwd_select(ra2_e, reg_write_m, wa3_m, reg_write_w, wa3_w);
    ldr_stall   = mem_to_reg_e && ((wa3_e == ra1_d) || (wa3_e == ra2_d));
    pc_wr_pend  = pc_src_d || pc_src_e || pc_src_m;
  end

  // Stall fetch/decode on a load-use or an in-flight PC write; flush on redirects.
  always_comb begin
    stall_f = ldr_stall || pc_wr_pend;
    stall_d = ldr_stall;
    flush_d = pc_wr_pend || pc_src_w || branch_taken_e;
    // A taken branch and a load-use in the same cycle still yield a single bubble.
    flush_e = ldr_stall || branch_taken_e;
  end

endmodule

// File: rtl/ctrl_pipeline.sv
// E/M/W control pipeline registers, hazard unit instance and hazard event counter.
module ctrl_pipeline
  import pipe_ctrl_pkg::*;
#(
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            RegWriteD,
  input  logic            MemWriteD,
  input  logic            MemtoRegD,
  input  logic            BranchD,
  input  logic            PCSrcD,
  input  logic            ALUSrcD,
  input  logic [1:0]      ALUControlD,
  input  logic [1:0]      FlagWriteD,
  input  logic [3:0]      CondD,
  input  logic [3:0]      RA1D,
  input  logic [3:0]      RA2D,
  input  logic [3:0]      WA3D,
  input  logic            RegWriteG,
  input  logic            MemWriteG,
  input  logic            PCSrcG,
  input  logic            BranchTakenE,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            MemtoRegE,
  output logic            BranchE,
  output logic            PCSrcE,
  output logic            ALUSrcE,
  output logic [1:0]      ALUControlE,
  output logic [1:0]      FlagWriteE,
  output logic [3:0]      CondE,
  output logic [3:0]      WA3E,
  output logic [3:0]      RA1E,
  output logic [3:0]      RA2E,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic            MemtoRegM,
  output logic            PCSrcM,
  output logic [3:0]      WA3M,
  output logic            RegWriteW,
  output logic            MemtoRegW,
  output logic            PCSrcW,
  output logic [3:0]      WA3W,
  output logic [1:0]      ForwardAE,
  output logic [1:0]      ForwardBE,
  output logic            StallF,
  output logic            StallD,
  output logic            FlushD,
  output logic            FlushE,
  output logic [CNTW-1:0] HazardCount
);

  ctrl_e_t         e_d, e_q;
  ctrl_m_t         m_d, m_q;
  ctrl_w_t         w_d, w_q;
  logic [CNTW-1:0] hz_cnt_d, hz_cnt_q;
  fwd_sel_t        fwd_a, fwd_b;

  hazard_unit u_hazard (
    .ra1_d          (RA1D),
    .ra2_d          (RA2D),
    .ra1_e          (e_q.ra1),
    .ra2_e          (e_q.ra2),
    .wa3_e          (e_q.wa3),
    .mem_to_reg_e   (e_q.mem_to_reg),
    .reg_write_m    (m_q.reg_write),
    .wa3_m          (m_q.wa3),
    .reg_write_w    (w_q.reg_write),
    .wa3_w          (w_q.wa3),
    .pc_src_d       (PCSrcD),
    .pc_src_e       (e_q.pc_src),
    .pc_src_m       (m_q.pc_src),
    .pc_src_w       (w_q.pc_src),
    .branch_taken_e (BranchTakenE),
    .forward_a_e    (fwd_a),
    .forward_b_e    (fwd_b),
    .stall_f        (StallF),
    .stall_d        (StallD),
    .flush_d        (FlushD),
    .flush_e        (FlushE)
  );

  // D->E next state: capture decoder fields, or a bubble when E is flushed.
  always_comb begin
    // NOTE: every always_comb output gets a full default first, so no path can infer a latch.
    e_d             = '0;
    e_d.reg_write   = RegWriteD;
    e_d.mem_write   = MemWriteD;
    e_d.mem_to_reg  = MemtoRegD;
    e_d.branch      = BranchD;
    e_d.pc_src      = PCSrcD;
    e_d.alu_src     = ALUSrcD;
    e_d.alu_control = ALUControlD;
    e_d.flag_write  = FlagWriteD;
    e_d.cond        = CondD;
    e_d.wa3         = WA3D;
    e_d.ra1         = RA1D;
    e_d.ra2         = RA2D;
    if (FlushE) begin
      e_d = '0;
    end
  end

  // E->M and M->W next state: condition-gated results move to M, M copies to W.
  always_comb begin
    m_d.reg_write  = RegWriteG;
    m_d.mem_write  = MemWriteG;
    m_d.mem_to_reg = e_q.mem_to_reg;
    m_d.pc_src     = PCSrcG;
    m_d.wa3        = e_q.wa3;
    w_d.reg_write  = m_q.reg_write;
    w_d.mem_to_reg = m_q.mem_to_reg;
    w_d.pc_src     = m_q.pc_src;
    w_d.wa3        = m_q.wa3;
  end

  // Saturating count of cycles that stall decode or flush execute.
  always_comb begin
    hz_cnt_d = hz_cnt_q;
    if ((StallD || FlushE) && (hz_cnt_q != '1)) begin
      hz_cnt_d = hz_cnt_q + 1'b1;
    end
  end

  // Pipeline and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: reset is the outer branch, so it wins over a same-cycle flush; state uses <= only.
    if (reset) begin
      e_q      <= '0;
      m_q      <= '0;
      w_q      <= '0;
      hz_cnt_q <= '0;
    end else begin
      e_q      <= e_d;
      m_q      <= m_d;
      w_q      <= w_d;
      hz_cnt_q <= hz_cnt_d;
    end
  end

  assign RegWriteE   = e_q.reg_write;
  assign MemWriteE   = e_q.mem_write;
  assign MemtoRegE   = e_q.mem_to_reg;
  assign BranchE     = e_q.branch;
  assign PCSrcE      = e_q.pc_src;
  assign ALUSrcE     = e_q.alu_src;
  assign ALUControlE = e_q.alu_control;
  assign FlagWriteE  = e_q.flag_write;
  assign CondE       = e_q.cond;
  assign WA3E        = e_q.wa3;
  assign RA1E        = e_q.ra1;
  assign RA2E        = e_q.ra2;
  assign RegWriteM   = m_q.reg_write;
  assign MemWriteM   = m_q.mem_write;
  assign MemtoRegM   = m_q.mem_to_reg;
  assign PCSrcM      = m_q.pc_src;
  assign WA3M        = m_q.wa3;
  assign RegWriteW   = w_q.reg_write;
  assign MemtoRegW   = w_q.mem_to_reg;
  assign PCSrcW      = w_q.pc_src;
  assign WA3W        = w_q.wa3;
  assign ForwardAE   = fwd_a;
  assign ForwardBE   = fwd_b;
  assign HazardCount = hz_cnt_q;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Directed bench for ctrl_pipeline: reset, forwarding, load-use, branch, PC write, counter saturation.
module tb_ctrl_pipeline;

  localparam int CNTW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            RegWriteD, MemWriteD, MemtoRegD, BranchD, PCSrcD, ALUSrcD;
  logic [1:0]      ALUControlD, FlagWriteD;
  logic [3:0]      CondD, RA1D, RA2D, WA3D;
  logic            RegWriteG, MemWriteG, PCSrcG, BranchTakenE;
  logic            RegWriteE, MemWriteE, MemtoRegE, BranchE, PCSrcE, ALUSrcE;
  logic [1:0]      ALUControlE, FlagWriteE;
  logic [3:0]      CondE, WA3E, RA1E, RA2E;
  logic            RegWriteM, MemWriteM, MemtoRegM, PCSrcM;
  logic [3:0]      WA3M;
  logic            RegWriteW, MemtoRegW, PCSrcW;
  logic [3:0]      WA3W;
  logic [1:0]      ForwardAE, ForwardBE;
  logic            StallF, StallD, FlushD, FlushE;
  logic [CNTW-1:0] HazardCount;

  int checks   = 0;
  int failures = 0;

  // Destination registers of instructions expected to retire, in order.
  logic [3:0] sb[$];

  always #5 clk = ~clk;

  // Stand-in for condlogic: every condition passes.
  assign RegWriteG    = RegWriteE;
  assign MemWriteG    = MemWriteE;
  assign PCSrcG       = PCSrcE;
  assign BranchTakenE = BranchE;

  ctrl_pipeline #(.CNTW(CNTW)) dut (
    .clk(clk), .reset(reset),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .MemtoRegD(MemtoRegD),
    .BranchD(BranchD), .PCSrcD(PCSrcD), .ALUSrcD(ALUSrcD),
    .ALUControlD(ALUControlD), .FlagWriteD(FlagWriteD), .CondD(CondD),
    .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
    .RegWriteG(RegWriteG), .MemWriteG(MemWriteG), .PCSrcG(PCSrcG),
    .BranchTakenE(BranchTakenE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemtoRegE(MemtoRegE),
    .BranchE(BranchE), .PCSrcE(PCSrcE), .ALUSrcE(ALUSrcE),
    .ALUControlE(ALUControlE), .FlagWriteE(FlagWriteE), .CondE(CondE),
    .WA3E(WA3E), .RA1E(RA1E), .RA2E(RA2E),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM),
    .PCSrcM(PCSrcM), .WA3M(WA3M),
    .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .PCSrcW(PCSrcW), .WA3W(WA3W),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .HazardCount(HazardCount)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_d(input logic rw, input logic mw, input logic m2r, input logic br,
                       input logic pcs, input logic [3:0] ra1, input logic [3:0] ra2,
                       input logic [3:0] wa3);
    RegWriteD   = rw;
    MemWriteD   = mw;
    MemtoRegD   = m2r;
    BranchD     = br;
    PCSrcD      = pcs;
    ALUSrcD     = 1'b0;
    ALUControlD = 2'b00;
    FlagWriteD  = 2'b00;
    CondD       = 4'hE;
    RA1D        = ra1;
    RA2D        = ra2;
    WA3D        = wa3;
    #1;
  endtask

  task automatic set_nop();
    set_d(0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0);
  endtask

  task automatic reset_pulse();
    set_nop();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Scoreboard: every register write leaving W must match the oldest expected destination.
  always @(negedge clk) begin
    if (!reset && RegWriteW) begin
      if (sb.size() == 0) begin
        check("unexpected_retire", 32'(RegWriteW), 32'd0);
      end else begin
        check("retire_wa3", 32'(WA3W), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    reset = 1'b1;
    set_nop();
    tick();
    tick();
    check("rst_stallf", 32'(StallF), 0);
    check("rst_flushd", 32'(FlushD), 0);
    check("rst_flushe", 32'(FlushE), 0);
    check("rst_regwe", 32'(RegWriteE), 0);
    check("rst_count", 32'(HazardCount), 0);
    reset = 1'b0;

    // Reset mid-stream: a captured instruction is wiped by the following reset edge.
    set_d(1, 0, 0, 0, 0, 4'h0, 4'h0, 4'h3);
    ALUControlD = 2'b01;
    FlagWriteD  = 2'b10;
    ALUSrcD     = 1'b1;
    #1;
    tick();
    check("cap_regwe", 32'(RegWriteE), 1);
    check("cap_wa3e", 32'(WA3E), 3);
    check("cap_aluc", 32'(ALUControlE), 1);
    check("cap_flagw", 32'(FlagWriteE), 2);
    check("cap_alusrc", 32'(ALUSrcE), 1);
    check("cap_cond", 32'(CondE), 4'hE);
    reset = 1'b1;
    tick();
    check("mid_rst_regwe", 32'(RegWriteE), 0);
    check("mid_rst_wa3e", 32'(WA3E), 0);
    check("mid_rst_cond", 32'(CondE), 0);
    check("mid_rst_regwm", 32'(RegWriteM), 0);
    check("mid_rst_wa3m", 32'(WA3M), 0);
    check("mid_rst_count", 32'(HazardCount), 0);
    set_nop();
    tick();
    reset = 1'b0;

    // ADD R1 ; SUB uses R1 (M forward) ; ORR uses R1 (W forward).
    reset_pulse();
    set_d(1, 0, 0, 0, 0, 4'h2, 4'h3, 4'h1);
    sb.push_back(4'h1);
    tick();
    set_d(1, 0, 0, 0, 0, 4'h1, 4'h5, 4'h4);
    sb.push_back(4'h4);
    check("add_no_stall", 32'(StallD), 0);
    tick();
    check("sub_fwd_a", 32'(ForwardAE), 2'b10);
    check("sub_fwd_b", 32'(ForwardBE), 2'b00);
    set_d(1, 0, 0, 0, 0, 4'h1, 4'h8, 4'h6);
    sb.push_back(4'h6);
    tick();
    check("orr_fwd_a", 32'(ForwardAE), 2'b01);
    check("orr_fwd_b", 32'(ForwardBE), 2'b00);
    set_nop();
    tick();
    tick();
    tick();
    check("fwd_count", 32'(HazardCount), 0);

    // LDR R2 ; ADD reads R2 through RA2D.
    reset_pulse();
    set_d(1, 0, 1, 0, 0, 4'h3, 4'h0, 4'h2);
    sb.push_back(4'h2);
    tick();
    set_d(1, 0, 0, 0, 0, 4'h6, 4'h2, 4'h5);
    check("ldr_stalld", 32'(StallD), 1);
    check("ldr_stallf", 32'(StallF), 1);
    check("ldr_flushe", 32'(FlushE), 1);
    check("ldr_flushd", 32'(FlushD), 0);
    tick();
    sb.push_back(4'h5);
    check("bubble_regwe", 32'(RegWriteE), 0);
    check("bubble_stalld", 32'(StallD), 0);
    check("bubble_flushe", 32'(FlushE), 0);
    check("ldr_count", 32'(HazardCount), 1);
    check("ldr_m2r_m", 32'(MemtoRegM), 1);
    tick();
    check("use_fwd_b", 32'(ForwardBE), 2'b01);
    check("use_fwd_a", 32'(ForwardAE), 2'b00);
    check("use_wa3e", 32'(WA3E), 5);
    check("ldr_m2r_w", 32'(MemtoRegW), 1);
    check("ldr_count_hold", 32'(HazardCount), 1);
    set_nop();
    tick();
    tick();
    tick();

    // Taken branch in E kills the instruction behind it.
    reset_pulse();
    set_d(0, 0, 0, 1, 0, 4'h0, 4'h0, 4'h0);
    tick();
    set_d(1, 0, 0, 0, 0, 4'h1, 4'h2, 4'h7);
    check("br_flushd", 32'(FlushD), 1);
    check("br_flushe", 32'(FlushE), 1);
    check("br_stallf", 32'(StallF), 0);
    tick();
    set_nop();
    check("br_next_regwe", 32'(RegWriteE), 0);
    check("br_next_wa3e", 32'(WA3E), 0);
    check("br_count", 32'(HazardCount), 1);
    tick();
    tick();
    tick();

    // Write to R15: StallF for D/E/M, FlushD through W; PC reads are never forwarded.
    reset_pulse();
    set_d(1, 0, 0, 0, 1, 4'h1, 4'h0, 4'hF);
    sb.push_back(4'hF);
    check("pc_d_stallf", 32'(StallF), 1);
    check("pc_d_flushd", 32'(FlushD), 1);
    tick();
    set_d(0, 0, 0, 0, 0, 4'hF, 4'hF, 4'h0);
    check("pc_e_stallf", 32'(StallF), 1);
    check("pc_e_flushd", 32'(FlushD), 1);
    check("pc_e_flushe", 32'(FlushE), 0);
    tick();
    set_nop();
    check("pc_m_stallf", 32'(StallF), 1);
    check("pc_m_flushd", 32'(FlushD), 1);
    check("pc_m_pcsrcm", 32'(PCSrcM), 1);
    check("pc_m_ra1e", 32'(RA1E), 4'hF);
    check("pc_m_fwd_a", 32'(ForwardAE), 2'b00);
    check("pc_m_fwd_b", 32'(ForwardBE), 2'b00);
    tick();
    check("pc_w_stallf", 32'(StallF), 0);
    check("pc_w_flushd", 32'(FlushD), 1);
    check("pc_w_pcsrcw", 32'(PCSrcW), 1);
    tick();
    check("pc_done_flushd", 32'(FlushD), 0);
    check("pc_count", 32'(HazardCount), 0);

    // Repeated load-use events saturate the 2-bit counter at 3.
    reset_pulse();
    for (int i = 0; i < 5; i++) begin
      set_d(0, 0, 1, 0, 0, 4'h0, 4'h0, 4'h2);
      tick();
      set_d(0, 0, 0, 0, 0, 4'h2, 4'h0, 4'h0);
      check("sat_stall", 32'(StallD), 1);
      tick();
      check("sat_count", 32'(HazardCount), (i < 3) ? i + 1 : 3);
      tick();
    end
    set_nop();
    tick();
    tick();
    tick();

    check("sb_drained", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
